pipe_hazard_sched: RTL

- Central stall/flush scheduler for the 5-stage MIPS pipeline; owns every pipeline-register write enable and bubble/flush control.
- Combines load-use hazard detection (EX load vs ID sources) with a variable-latency data-memory handshake and taken-branch IF/ID flush.
- Tracks multi-cycle memory waits with an FSM and watchdog.
- Sits beside the hazard/forwarding logic; drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipe_hazard_sched.sv | 102 ++++++++++
 1 files changed

// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched: stall/flush scheduler for the 5-stage pipeline (load-use bubble, memory-wait freeze with watchdog, branch flush).
// Define SCHED_PERF_CNT_EN to add saturating load-use, freeze and branch-flush counters.
module pipe_hazard_sched #(
    parameter int TO_W        = 4,
    parameter int MEM_TIMEOUT = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_rt,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic [5:0] ID_Op,
    input  logic       ID_BranchTaken,
    input  logic       MEM_Access,
    input  logic       Mem_Ready,
    output logic       PC_WriteEn,
    output logic       IFID_WriteEn,
    output logic       IDEX_WriteEn,
    output logic       EXMEM_WriteEn,
    output logic       MEMWB_WriteEn,
    output logic       Stall_flush,
    output logic       IFID_flush,
    output logic       Mem_Timeout,
    output logic [1:0] Sched_State
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [15:0] Cnt_LU,
    output logic [15:0] Cnt_MW,
    output logic [15:0] Cnt_BR
`endif
);
    typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, TIMEOUT_REL = 2'b10, UNUSED = 2'b11} state_e;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);
    state_e          state_q, state_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            to_q;
    logic            lu, mw, freeze, expire, stall, flush;
    // lw and xori write rt, so only rs can collide for them
    assign lu = EX_MemRead && (EX_rt == ID_rs ||
                (EX_rt == ID_rt && ID_Op != 6'b100011 && ID_Op != 6'b001110));
    assign mw = MEM_Access && !Mem_Ready;
    always_comb begin
        freeze  = 1'b0;
        expire  = 1'b0;
        state_d = RUN;
        wd_d    = wd_q;
        case (state_q)
            RUN: begin
                freeze  = mw;
                state_d = mw ? MEM_WAIT : RUN;
                wd_d    = mw ? TO_W'(1) : wd_q;
            end
            MEM_WAIT: begin
                freeze  = !Mem_Ready;
                expire  = !Mem_Ready && wd_q == TO_LIM;
                state_d = Mem_Ready ? RUN : (expire ? TIMEOUT_REL : MEM_WAIT);
                wd_d    = (freeze && !expire) ? wd_q + TO_W'(1) : wd_q;
            end
            default: ;
        endcase
    end
    assign stall         = rst_n && !freeze && lu;
    assign flush         = rst_n && !freeze && !lu && ID_BranchTaken;
    assign PC_WriteEn    = rst_n && !freeze && !lu;
    assign IFID_WriteEn  = rst_n && !freeze && !lu;
    assign IDEX_WriteEn  = rst_n && !freeze;
    assign EXMEM_WriteEn = rst_n && !freeze;
    assign MEMWB_WriteEn = rst_n && !freeze;
    assign Stall_flush   = stall;
    assign IFID_flush    = flush;
    assign Mem_Timeout   = rst_n && (to_q || expire);
    assign Sched_State   = state_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wd_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            to_q    <= to_q || expire;
        end
    end
`ifdef SCHED_PERF_CNT_EN
    logic [15:0] cnt_lu_q, cnt_mw_q, cnt_br_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_lu_q <= '0;
            cnt_mw_q <= '0;
            cnt_br_q <= '0;
        end else begin
            cnt_lu_q <= cnt_lu_q + {15'd0, stall && !(&cnt_lu_q)};
            cnt_mw_q <= cnt_mw_q + {15'd0, freeze && !(&cnt_mw_q)};
            cnt_br_q <= cnt_br_q + {15'd0, flush && !(&cnt_br_q)};
        end
    end
    assign Cnt_LU = cnt_lu_q;
    assign Cnt_MW = cnt_mw_q;
    assign Cnt_BR = cnt_br_q;
`endif
endmodule
